// File: rtl/rehsd_gfx_pkg.sv
// Shared types and defaults for the PL rectangle path feeding rehsd_gfx_writer.
package rehsd_gfx_pkg;

    localparam int unsigned H_RES_DEF           = 1280;
    localparam int unsigned V_RES_DEF           = 720;
    localparam int unsigned BYTES_PER_PIXEL_DEF = 4;
    localparam int unsigned STRIDE_DEF          = 5120;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLIP,
        ST_ISSUE,
        ST_WAIT,
        ST_ADVANCE,
        ST_DONE
    } rast_state_e;

    typedef struct packed {
        logic [31:0] base;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] w;
        logic [15:0] h;
        logic [31:0] color;
    } rect_cmd_t;

    // Exclusive end coordinate clipped to the frame edge; 17-bit sum so x+w never wraps.
    function automatic logic [16:0] clip_end(input logic [15:0] org,
                                             input logic [15:0] len,
                                             input logic [16:0] lim);
        logic [16:0] sum;
        sum = {1'b0, org} + {1'b0, len};
        return (sum > lim) ? lim : sum;
    endfunction

endpackage

// File: rtl/rehsd_txn_handshake.sv
// Per-pixel writer handshake: init-hold timing, txn_done edge detection, completion timeout.
module rehsd_txn_handshake #(
    parameter int unsigned INIT_CYCLES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic issue_i,
    input  logic wait_i,
    input  logic txn_done_i,
    output logic init_txn_o,
    output logic go_o,
    output logic ack_o,
    output logic timeout_o
);

    localparam int unsigned IW = $clog2(INIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [IW-1:0] init_cnt_q, init_cnt_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          done_prev_q;

    // Counters run only while their phase is active; the previous txn_done level is tracked every cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            done_prev_q <= 1'b0;
        end else begin
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            done_prev_q <= txn_done_i;
        end
    end

    // A level already high when waiting begins has no rising edge, so it never acknowledges.
    always_comb begin
        init_cnt_d = issue_i ? init_cnt_q + 1'b1 : '0;
        wait_cnt_d = wait_i  ? wait_cnt_q + 1'b1 : '0;
        init_txn_o = issue_i;
        go_o       = issue_i && (init_cnt_q == IW'(INIT_CYCLES - 1));
        ack_o      = wait_i && txn_done_i && !done_prev_q;
        timeout_o  = wait_i && !ack_o && (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    end

endmodule

// File: rtl/rehsd_rect_rasterizer.sv
// Rectangle command stage: clips to the frame and walks pixels row-major into rehsd_gfx_writer.
module rehsd_rect_rasterizer
    import rehsd_gfx_pkg::*;
#(
    parameter int unsigned H_RES           = H_RES_DEF,
    parameter int unsigned V_RES           = V_RES_DEF,
    parameter int unsigned BYTES_PER_PIXEL = BYTES_PER_PIXEL_DEF,
    parameter int unsigned STRIDE          = STRIDE_DEF,
    parameter int unsigned INIT_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic [31:0] fb_base,
    input  logic [15:0] rect_x,
    input  logic [15:0] rect_y,
    input  logic [15:0] rect_w,
    input  logic [15:0] rect_h,
    input  logic [31:0] rect_color,
    output logic [31:0] addr_to_write,
    output logic [31:0] color_to_write,
    output logic        axi_init_txn,
    input  logic        axi_txn_done,
    input  logic        axi_error,
    output logic        busy,
    output logic        done,
    output logic        err_sticky,
    output logic        timeout_sticky,
    output logic [31:0] pixel_count
);

    rast_state_e state_q, state_d;
    rect_cmd_t   cmd_q;
    logic [16:0] x_end_q, y_end_q;
    logic [15:0] col_q, row_q;
    logic [31:0] row_addr_q, cur_addr_q;
    logic [31:0] pixel_count_q;
    logic        err_q, tmo_q;

    logic        hs_go, hs_ack, hs_timeout;
    logic [16:0] x_end_c, y_end_c;
    logic        empty_c, more_cols, more_rows;
    logic [31:0] addr_c;

    rehsd_txn_handshake #(
        .INIT_CYCLES   (INIT_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_handshake (
        .clk_i     (aclk),
        .rst_ni    (aresetn),
        .issue_i   (state_q == ST_ISSUE),
        .wait_i    (state_q == ST_WAIT),
        .txn_done_i(axi_txn_done),
        .init_txn_o(axi_init_txn),
        .go_o      (hs_go),
        .ack_o     (hs_ack),
        .timeout_o (hs_timeout)
    );

    // Clip window, first-pixel address and the row/column continuation tests.
    always_comb begin
        x_end_c   = clip_end(cmd_q.x, cmd_q.w, 17'(H_RES));
        y_end_c   = clip_end(cmd_q.y, cmd_q.h, 17'(V_RES));
        empty_c   = (32'(cmd_q.x) >= H_RES) || (32'(cmd_q.y) >= V_RES) ||
                    (cmd_q.w == '0) || (cmd_q.h == '0);
        addr_c    = cmd_q.base + 32'(cmd_q.y) * 32'(STRIDE) + 32'(cmd_q.x) * 32'(BYTES_PER_PIXEL);
        more_cols = ({1'b0, col_q} + 17'd1) < x_end_q;
        more_rows = ({1'b0, row_q} + 17'd1) < y_end_q;
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode; an abort on timeout skips ADVANCE and ends the command.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = ST_CLIP;
            ST_CLIP:    state_d = empty_c ? ST_DONE : ST_ISSUE;
            ST_ISSUE:   if (hs_go) state_d = ST_WAIT;
            ST_WAIT:    if (hs_ack) state_d = ST_ADVANCE;
                        else if (hs_timeout) state_d = ST_DONE;
            ST_ADVANCE: state_d = (more_cols || more_rows) ? ST_ISSUE : ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Command latch, walk position, addresses and result flags.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cmd_q         <= '0;
            x_end_q       <= '0;
            y_end_q       <= '0;
            col_q         <= '0;
            row_q         <= '0;
            row_addr_q    <= '0;
            cur_addr_q    <= '0;
            pixel_count_q <= '0;
            err_q         <= 1'b0;
            tmo_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    cmd_q         <= '{base: fb_base, x: rect_x, y: rect_y, w: rect_w,
                                       h: rect_h, color: rect_color};
                    pixel_count_q <= '0;
                    err_q         <= 1'b0;
                    tmo_q         <= 1'b0;
                end
                ST_CLIP: begin
                    x_end_q    <= x_end_c;
                    y_end_q    <= y_end_c;
                    col_q      <= cmd_q.x;
                    row_q      <= cmd_q.y;
                    row_addr_q <= addr_c;
                    cur_addr_q <= addr_c;
                end
                ST_WAIT: begin
                    if (hs_ack) begin
                        pixel_count_q <= pixel_count_q + 32'd1;
                        if (axi_error) err_q <= 1'b1;
                    end else if (hs_timeout) begin
                        tmo_q <= 1'b1;
                    end
                end
                ST_ADVANCE: begin
                    if (more_cols) begin
                        col_q      <= col_q + 16'd1;
                        cur_addr_q <= cur_addr_q + 32'(BYTES_PER_PIXEL);
                    end else if (more_rows) begin
                        row_q      <= row_q + 16'd1;
                        col_q      <= cmd_q.x;
                        row_addr_q <= row_addr_q + 32'(STRIDE);
                        cur_addr_q <= row_addr_q + 32'(STRIDE);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status decode is purely from state, so reset clears it asynchronously.
    always_comb begin
        addr_to_write  = cur_addr_q;
        color_to_write = cmd_q.color;
        busy           = (state_q == ST_CLIP) || (state_q == ST_ISSUE) ||
                         (state_q == ST_WAIT) || (state_q == ST_ADVANCE);
        done           = (state_q == ST_DONE);
        err_sticky     = err_q;
        timeout_sticky = tmo_q;
        pixel_count    = pixel_count_q;
    end

endmodule

// File: tb/tb_rehsd_rect_rasterizer.sv
// Self-checking bench for rehsd_rect_rasterizer with a behavioural writer and an address scoreboard.
module tb_rehsd_rect_rasterizer;

    localparam int LAT = 5;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] fb_base = '0;
    logic [15:0] rect_x = '0, rect_y = '0, rect_w = '0, rect_h = '0;
    logic [31:0] rect_color = '0;
    logic [31:0] addr_to_write, color_to_write, pixel_count;
    logic        axi_init_txn, axi_txn_done, axi_error;
    logic        busy, done, err_sticky, timeout_sticky;

    always #5 aclk = ~aclk;

    rehsd_rect_rasterizer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start),
        .fb_base       (fb_base),
        .rect_x        (rect_x),
        .rect_y        (rect_y),
        .rect_w        (rect_w),
        .rect_h        (rect_h),
        .rect_color    (rect_color),
        .addr_to_write (addr_to_write),
        .color_to_write(color_to_write),
        .axi_init_txn  (axi_init_txn),
        .axi_txn_done  (axi_txn_done),
        .axi_error     (axi_error),
        .busy          (busy),
        .done          (done),
        .err_sticky    (err_sticky),
        .timeout_sticky(timeout_sticky),
        .pixel_count   (pixel_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] color;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Writer model: drops done on an init rising edge, raises done (and maybe error) LAT cycles later.
    logic respond_en = 1'b1;
    int   err_pix = -1;
    int   pix_idx;
    int   lat_cnt;
    logic pend, init_prev_m;

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            axi_txn_done <= 1'b0;
            axi_error    <= 1'b0;
            init_prev_m  <= 1'b0;
            pend         <= 1'b0;
            lat_cnt      <= 0;
            pix_idx      <= 0;
        end else begin
            init_prev_m <= axi_init_txn;
            if (axi_init_txn && !init_prev_m) begin
                axi_txn_done <= 1'b0;
                axi_error    <= 1'b0;
                pend         <= 1'b1;
                lat_cnt      <= LAT;
                pix_idx      <= pix_idx + 1;
            end else if (pend && respond_en) begin
                if (lat_cnt <= 1) begin
                    axi_txn_done <= 1'b1;
                    axi_error    <= (pix_idx == err_pix);
                    pend         <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end

    // Monitor: score each issued pixel, measure init width, count done pulses.
    int   init_rises = 0;
    int   done_pulses = 0;
    int   init_len = 0;
    logic init_seen = 1'b0;

    always @(negedge aclk) begin
        if (aresetn) begin
            if (done) done_pulses++;
            if (axi_init_txn && !init_seen) begin
                init_rises++;
                check_eq("sb_nonempty", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check_eq("addr", addr_to_write, mon_e.addr);
                    check_eq("color", color_to_write, mon_e.color);
                end
            end
            if (axi_init_txn) init_len++;
            else if (init_len != 0) begin
                check_eq("init_len", 32'(init_len), 2);
                init_len = 0;
            end
            init_seen = axi_init_txn;
        end else begin
            init_seen = 1'b0;
            init_len  = 0;
        end
    end

    task automatic push_expected(input logic [31:0] base, input int x, input int y,
                                 input int w, input int h, input logic [31:0] col);
        int xe, ye;
        logic [31:0] a;
        if (x >= 1280 || y >= 720 || w == 0 || h == 0) return;
        xe = (x + w > 1280) ? 1280 : x + w;
        ye = (y + h > 720) ? 720 : y + h;
        for (int r = y; r < ye; r++) begin
            for (int c = x; c < xe; c++) begin
                a = base + 32'(r) * 32'd5120 + 32'(c) * 32'd4;
                sb_q.push_back('{addr: a, color: col});
            end
        end
    endtask

    task automatic drive_cmd(input logic [31:0] base, input logic [15:0] x, input logic [15:0] y,
                             input logic [15:0] w, input logic [15:0] h, input logic [31:0] col);
        @(posedge aclk); #1;
        fb_base = base; rect_x = x; rect_y = y; rect_w = w; rect_h = h; rect_color = col;
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge aclk);
            n++;
        end
        check_eq({tag, "_done_seen"}, 32'(done), 1);
        @(negedge aclk);
    endtask

    task automatic run_cmd(input string tag, input logic [31:0] base, input int x, input int y,
                           input int w, input int h, input logic [31:0] col,
                           input int exp_pc, input logic exp_err);
        int d0;
        d0 = done_pulses;
        push_expected(base, x, y, w, h, col);
        drive_cmd(base, 16'(x), 16'(y), 16'(w), 16'(h), col);
        wait_done(40 * (exp_pc + 1), tag);
        check_eq({tag, "_pixel_count"}, pixel_count, 32'(exp_pc));
        check_eq({tag, "_err"}, 32'(err_sticky), 32'(exp_err));
        check_eq({tag, "_tmo"}, 32'(timeout_sticky), 0);
        check_eq({tag, "_done_pulses"}, 32'(done_pulses - d0), 1);
        check_eq({tag, "_sb_left"}, 32'(sb_q.size()), 0);
        check_eq({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d0, r0, n;

        // Reset state
        repeat (3) @(negedge aclk);
        check_eq("rst_addr", addr_to_write, 0);
        check_eq("rst_color", color_to_write, 0);
        check_eq("rst_pixel_count", pixel_count, 0);
        check_eq("rst_flags", {27'd0, busy, done, axi_init_txn, err_sticky, timeout_sticky}, 0);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);

        // Basic 3x2 rectangle; first address cross-checked against a hand value
        check_eq("hand_addr0", 32'h30900000 + 32'd20 * 32'd5120 + 32'd40, 32'h30919028);
        run_cmd("rect3x2", 32'h30900000, 10, 20, 3, 2, 32'hFF00FF00, 6, 1'b0);

        // Bottom-right clip to 2 pixels
        run_cmd("clip", 32'h30900000, 1278, 719, 10, 10, 32'h0000FFFF, 2, 1'b0);

        // Empty command (w=0): done two cycles after start, no init
        d0 = done_pulses; r0 = init_rises;
        @(posedge aclk); #1;
        fb_base = 32'h30900000; rect_x = 16'd5; rect_y = 16'd5; rect_w = 16'd0; rect_h = 16'd4;
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        @(negedge aclk);
        check_eq("w0_busy_clip", 32'(busy), 1);
        check_eq("w0_done_early", 32'(done), 0);
        @(negedge aclk);
        check_eq("w0_done", 32'(done), 1);
        check_eq("w0_pixel_count", pixel_count, 0);
        @(negedge aclk);
        check_eq("w0_done_width", 32'(done), 0);

        // x=1280: same empty timing; a start held over DONE is ignored there, accepted in IDLE
        @(posedge aclk); #1;
        rect_x = 16'd1280; rect_w = 16'd4;
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check_eq("x1280_done", 32'(done), 1);
        start = 1'b1;
        @(posedge aclk);
        @(posedge aclk); #1;
        start = 1'b0;
        @(negedge aclk);
        check_eq("done_start_busy", 32'(busy), 1);
        check_eq("done_start_notdone", 32'(done), 0);
        @(negedge aclk);
        check_eq("done_start_done", 32'(done), 1);
        @(negedge aclk);
        check_eq("empty_no_init", 32'(init_rises - r0), 0);
        check_eq("empty_done_pulses", 32'(done_pulses - d0), 3);
        check_eq("empty_pixel_count", pixel_count, 0);

        // Error on pixel 2 of 4: command continues
        err_pix = pix_idx + 2;
        run_cmd("err", 32'h10000000, 100, 50, 4, 1, 32'h11223344, 4, 1'b1);
        err_pix = -1;

        // Writer never completes: timeout abort; mid-command start ignored
        respond_en = 1'b0;
        d0 = done_pulses;
        push_expected(32'h20000000, 5, 5, 1, 1, 32'h12345678);
        drive_cmd(32'h20000000, 16'd5, 16'd5, 16'd1, 16'd1, 32'h12345678);
        n = 0;
        while (done !== 1'b1 && n < 5000) begin
            @(negedge aclk);
            n++;
            if (n == 20) begin
                rect_color = 32'hDEADBEEF; rect_x = 16'd9;
                start = 1'b1;
            end
            if (n == 21) start = 1'b0;
            if (n == 30) check_eq("tmo_color_held", color_to_write, 32'h12345678);
        end
        check_eq("tmo_done_cycle", 32'(n), 4100);
        check_eq("tmo_sticky", 32'(timeout_sticky), 1);
        check_eq("tmo_err_cleared", 32'(err_sticky), 0);
        check_eq("tmo_pixel_count", pixel_count, 0);
        @(negedge aclk);
        check_eq("tmo_done_pulses", 32'(done_pulses - d0), 1);
        check_eq("tmo_sb_left", 32'(sb_q.size()), 0);

        // Asynchronous reset while waiting
        push_expected(32'h40000000, 7, 3, 1, 1, 32'hA5A5A5A5);
        drive_cmd(32'h40000000, 16'd7, 16'd3, 16'd1, 16'd1, 32'hA5A5A5A5);
        repeat (10) @(negedge aclk);
        check_eq("pre_rst_busy", 32'(busy), 1);
        #2;
        aresetn = 1'b0;
        #1;
        check_eq("arst_addr", addr_to_write, 0);
        check_eq("arst_color", color_to_write, 0);
        check_eq("arst_flags", {27'd0, busy, done, axi_init_txn, err_sticky, timeout_sticky}, 0);
        sb_q.delete();
        @(negedge aclk);
        aresetn = 1'b1;
        respond_en = 1'b1;
        repeat (2) @(negedge aclk);
        run_cmd("post_rst", 32'h40000000, 0, 0, 1, 1, 32'h0BADCAFE, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
